// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall controller for a 5-stage pipeline: load-use bubbles, taken-branch squash,
// memory-wait freeze with timeout. Optional stall-cycle counter enabled by macro STALL_COUNTER_EN.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs_addr,
  input  logic [4:0]  id_rt_addr,
  input  logic        id_uses_rt,
  input  logic        ex_MemRead,
  input  logic [4:0]  ex_write_reg_addr,
  input  logic        branch_taken,
  input  logic        mem_access,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        mem_wb_flush,
  output logic        mem_timeout,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERROR    = 2'b10
  } state_t;

  localparam logic [15:0] LP_WAIT_LAST = 16'(MEM_TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_wait_cnt;
  logic [15:0] w_wait_next;
  logic        r_mem_timeout;
  logic        w_set_timeout;
  logic        w_load_use;
  logic        w_run_eval;
  logic        w_mem_hold;
  logic        w_all_off;

  assign w_load_use = ex_MemRead && (ex_write_reg_addr != 5'd0) &&
                      ((ex_write_reg_addr == id_rs_addr) ||
                       (id_uses_rt && (ex_write_reg_addr == id_rt_addr)));

  always_comb begin
    w_next_state  = r_state;
    w_wait_next   = r_wait_cnt;
    w_set_timeout = 1'b0;
    w_run_eval    = 1'b0;
    w_mem_hold    = 1'b0;
    w_all_off     = 1'b0;

    case (r_state)
      RUN: begin
        if (mem_access && !mem_ready) begin
          w_mem_hold   = 1'b1;
          w_next_state = MEM_WAIT;
          w_wait_next  = 16'd0;
        end else begin
          w_run_eval = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!mem_ready) begin
          w_mem_hold  = 1'b1;
          w_wait_next = r_wait_cnt + 16'd1;
          if (r_wait_cnt == LP_WAIT_LAST) begin
            w_next_state  = ERROR;
            w_set_timeout = 1'b1;
          end
        end else begin
          // The access completed: hazards frozen during the wait are honoured now.
          w_run_eval   = 1'b1;
          w_next_state = RUN;
        end
      end
      ERROR: begin
        w_all_off = 1'b1;
      end
      default: begin
        w_all_off    = 1'b1;
        w_next_state = RUN;
      end
    endcase

    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;

    if (w_run_eval) begin
      // A taken branch squashes the ID instruction, so its load-use stall is moot.
      if (branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (w_load_use) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end

    if (w_mem_hold) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end

    if (w_all_off || rst) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      mem_wb_flush = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= RUN;
      r_wait_cnt    <= 16'd0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_wait_next;
      if (w_set_timeout) begin
        r_mem_timeout <= 1'b1;
      end
    end
  end

  assign mem_timeout = r_mem_timeout;

`ifdef STALL_COUNTER_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= 32'd0;
    end else if (!pc_en && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`else
  assign stall_cycles = 32'h0;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255: maximum number of MEM_WAIT cycles before the block flags an error; legal range 1..65535.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 id_rs_addr  in  5  rs field of the instruction in ID.
REQ-005 id_rt_addr  in  5  rt field of the instruction in ID.
REQ-006 id_uses_rt  in  1  the ID instruction reads rt as a source.
REQ-007 ex_MemRead  in  1  the instruction in EX is a load.
REQ-008 ex_write_reg_addr  in  5  destination register of the instruction in EX.
REQ-009 branch_taken  in  1  branch or jump resolved taken in EX.
REQ-010 mem_access  in  1  the MEM-stage instruction has MemRead or MemWrite set.
REQ-011 mem_ready  in  1  data memory has completed the current access.
REQ-012 pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  pipeline register and PC enables.
REQ-013 if_id_flush, id_ex_flush, mem_wb_flush  out  1 each  load a bubble (all control bits 0) into that register.
REQ-014 mem_timeout  out  1  sticky error flag.
REQ-015 stall_cycles  out  32  stall performance counter (see Configuration).

Function
REQ-016 The FSM SHALL have three states: RUN=2'b00, MEM_WAIT=2'b01, ERROR=2'b10; encoding 2'b11 SHALL go to RUN on the next cycle.
REQ-017 All enable and flush outputs SHALL be combinational (Mealy) functions of the current state and the inputs, taking effect in the same cycle.
REQ-018 Default, with no event active: all enables = 1 and all flushes = 0.
REQ-019 Load-use is detected when all of the following hold:
- ex_MemRead = 1;
- ex_write_reg_addr != 0;
- ex_write_reg_addr == id_rs_addr, or (id_uses_rt = 1 and ex_write_reg_addr == id_rt_addr).
REQ-020 On load-use in RUN: pc_en = 0, if_id_en = 0, id_ex_flush = 1; one bubble per detection; the state remains RUN.
REQ-021 On branch_taken in RUN: if_id_flush = 1, id_ex_flush = 1, pc_en = 1.
REQ-022 Branch SHALL override load-use; the ID instruction is squashed and no stall is applied.
REQ-023 On mem_access = 1 and mem_ready = 0 in RUN:
- pc_en, if_id_en, id_ex_en, ex_mem_en = 0;
- mem_wb_flush = 1;
- all other flushes = 0;
- next state MEM_WAIT, wait counter cleared to 0.
REQ-024 Memory stall SHALL override branch and load-use; a frozen taken branch SHALL apply its flush in the cycle the stall releases.
REQ-025 In MEM_WAIT with mem_ready = 0: outputs as in REQ-023, and the 16-bit wait counter increments by 1.
REQ-026 In MEM_WAIT with mem_ready = 1: outputs are evaluated as in RUN (REQ-018..REQ-022), and the next state is RUN.
REQ-027 In MEM_WAIT, when the wait counter equals MEM_TIMEOUT-1 and mem_ready = 0: next state ERROR, and mem_timeout is set.
REQ-028 In ERROR: all enables = 0 and all flushes = 0; the block is held until rst; mem_timeout = 1.
REQ-029 A zero-latency access (mem_access = 1 with mem_ready = 1 in RUN) SHALL cause no stall.

Reset
REQ-030 Reset values: state RUN, wait counter 0, mem_timeout 0, stall_cycles 0.
REQ-031 While rst = 1: all enables = 0 and all flushes = 0.
REQ-032 Reset asserted from any state, including MEM_WAIT and ERROR, SHALL yield RUN on the first cycle after rst falls.

Configuration
REQ-033 With macro STALL_COUNTER_EN defined: stall_cycles increments by 1 on every cycle (not in reset) where pc_en = 0, and saturates at 32'hFFFFFFFF.
REQ-034 With STALL_COUNTER_EN undefined: stall_cycles is tied to 32'h0 and no counter flops are synthesized.

Verification
REQ-035 ex_MemRead = 1, ex_write_reg_addr = 5, id_rs_addr = 5 -> pc_en = 0, if_id_en = 0, id_ex_flush = 1 for exactly that cycle; the same stimulus with ex_write_reg_addr = 0 -> no stall.
REQ-036 Load-use on rt (id_rt_addr = 8, ex_write_reg_addr = 8), with id_uses_rt = 0 -> no stall; with id_uses_rt = 1 -> stall.
REQ-037 mem_access = 1, mem_ready low for 3 cycles then high -> stall for 3 cycles, mem_wb_flush = 1 during the stall, and enables back to 1 on the 4th cycle; stall_cycles = 3 with STALL_COUNTER_EN.
REQ-038 branch_taken = 1 during a 2-cycle memory stall -> no flushes while stalled; if_id_flush = id_ex_flush = 1 in the release cycle.
REQ-039 MEM_TIMEOUT = 4, mem_ready held 0 -> mem_timeout = 1 after the 4th wait cycle, all enables = 0 in ERROR; rst pulse -> RUN with mem_timeout = 0.
REQ-040 rst asserted in MEM_WAIT -> all outputs 0 during reset, then normal RUN behaviour with stall_cycles = 0.
